// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data memory and the future load/store unit.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } mem_state_t;

  // Byte-lane write mask for a naturally aligned access of the given size.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'(4'b0001 << lane);
      SZ_HALF: be = 4'(4'b0011 << lane);
      SZ_WORD: be = 4'hF;
      default: be = 4'h0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects a byte/half/word from a little-endian memory word and extends it.
module mem_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] rd_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Field select by lane, then zero- or sign-extend from the field's top bit.
  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = word[{lane[1], 4'b0000} +: 16];
    rd_c     = '0;
    case (size)
      SZ_BYTE: rd_c = {{24{~uns & byte_sel[7]}}, byte_sel};
      SZ_HALF: rd_c = {{16{~uns & half_sel[15]}}, half_sel};
      SZ_WORD: rd_c = word;
      default: rd_c = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// Byte/half/word data memory with req/ready handshake, registered read,
// fault reporting and a sequential zero-fill after reset.
module data_memory_sized
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned IDX_W          = $clog2(DEPTH),
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic        ready,
  output logic        resp_valid,
  output logic [31:0] RD,
  output logic        err,
  output logic        busy
);

  logic [31:0] mem [DEPTH];

  mem_state_t       state_q, next_state;
  logic [IDX_W-1:0] clr_idx_q, clr_next;
  logic             ready_q, ready_d, busy_q, busy_d;
  logic             resp_valid_q, err_q, ld_ok_q;
  logic [1:0]       lane_q, size_q;
  logic             uns_q;
  logic [31:0]      rdata_q;
  logic [31:0]      align_rd_c;

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             oor, misaligned, fault, accept, rd_en;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data, st_data;

  // Address decode and fault classification.
  always_comb begin
    idx        = A[IDX_W+1:2];
    lane       = A[1:0];
    oor        = (A[31:2] >= 30'(DEPTH));
    misaligned = (size == 2'b11) ||
                 ((size == SZ_HALF) && A[0]) ||
                 ((size == SZ_WORD) && (A[1:0] != 2'b00));
    fault      = oor | misaligned;
    accept     = req & ready_q;
    rd_en      = accept & ~we & ~fault;
    case (size)
      SZ_BYTE: st_data = {4{WD[7:0]}};
      SZ_HALF: st_data = {2{WD[15:0]}};
      default: st_data = WD;
    endcase
  end

  // State register, fill counter and handshake outputs.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= CLEAR_ON_RESET;
    end else begin
      state_q   <= next_state;
      clr_idx_q <= clr_next;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  // Next state and the single array write port (fill or store).
  always_comb begin
    next_state = state_q;
    clr_next   = '0;
    wr_en      = 1'b0;
    wr_idx     = idx;
    wr_be      = byte_en(size, lane);
    wr_data    = st_data;
    case (state_q)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_idx  = clr_idx_q;
        wr_be   = 4'hF;
        wr_data = '0;
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          next_state = IDLE;
        end else begin
          clr_next = clr_idx_q + IDX_W'(1);
        end
      end
      IDLE: begin
        wr_en = accept & we & ~fault;
      end
      default: next_state = IDLE;
    endcase
    ready_d = (next_state == IDLE);
    busy_d  = (next_state == CLEAR);
  end

  // Array: byte-lane writes and registered read, no reset so it maps to block RAM.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (rd_en) rdata_q <= mem[idx];
  end

  // One-cycle response bookkeeping for the accepted request.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      ld_ok_q      <= 1'b0;
      lane_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
    end else begin
      resp_valid_q <= accept;
      err_q        <= accept & fault;
      ld_ok_q      <= rd_en;
      if (accept) begin
        lane_q <= lane;
        size_q <= size;
        uns_q  <= uns;
      end
    end
  end

  mem_load_align u_align (
    .word (rdata_q),
    .lane (lane_q),
    .size (size_q),
    .uns  (uns_q),
    .rd_c (align_rd_c)
  );

  assign RD         = ld_ok_q ? align_rd_c : '0;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Self-checking bench for data_memory_sized (DEPTH=16) with a byte-array model.
module tb_data_memory_sized;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] A = '0, WD = '0;
  logic        ready, resp_valid, err, busy;
  logic [31:0] RD;

  int checks = 0;
  int errors = 0;

  // Expected response for the request driven in the previous cycle.
  logic        exp_v = 1'b0, exp_e = 1'b0;
  logic [31:0] exp_rd = '0;
  logic [7:0]  ref_mem [64];

  data_memory_sized #(.DEPTH(16)) dut (
    .CLK(CLK), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
    .A(A), .WD(WD), .ready(ready), .resp_valid(resp_valid), .RD(RD),
    .err(err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Counts fill cycles from the current negedge; model memory becomes all zero.
  task automatic wait_fill();
    int cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      chk("fill_ready", 32'(ready), 32'd0);
      chk("fill_resp", 32'(resp_valid), 32'd0);
      cnt++;
      @(negedge CLK);
    end
    chk("fill_cycles", 32'(cnt), 32'd16);
    req = 1'b0;
    chk("ready_after_fill", 32'(ready), 32'd1);
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    exp_v = 1'b0; exp_e = 1'b0; exp_rd = '0;
  endtask

  // Check the previous cycle's response, then drive (and model) one new cycle.
  task automatic step(input logic r, input logic w, input logic [1:0] sz,
                      input logic u, input logic [31:0] a, input logic [31:0] wd);
    logic        fault;
    logic [5:0]  ba;
    logic [15:0] h;
    logic [7:0]  b;
    chk("ready", 32'(ready), 32'd1);
    chk("resp_valid", 32'(resp_valid), 32'(exp_v));
    chk("err", 32'(err), 32'(exp_e));
    chk("RD", RD, exp_rd);
    exp_v = 1'b0; exp_e = 1'b0; exp_rd = '0;
    if (r) begin
      fault = (a[31:2] >= 30'd16) || (sz == 2'b11) ||
              (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      ba = a[5:0];
      exp_v = 1'b1;
      exp_e = fault;
      if (!fault) begin
        if (w) begin
          case (sz)
            2'b00: ref_mem[ba] = wd[7:0];
            2'b01: begin ref_mem[ba] = wd[7:0]; ref_mem[ba + 6'd1] = wd[15:8]; end
            default: for (int i = 0; i < 4; i++) ref_mem[ba + 6'(i)] = wd[8*i +: 8];
          endcase
        end else begin
          case (sz)
            2'b00: begin
              b = ref_mem[ba];
              exp_rd = u ? {24'h0, b} : {{24{b[7]}}, b};
            end
            2'b01: begin
              h = {ref_mem[ba + 6'd1], ref_mem[ba]};
              exp_rd = u ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: exp_rd = {ref_mem[ba + 6'd3], ref_mem[ba + 6'd2],
                               ref_mem[ba + 6'd1], ref_mem[ba]};
          endcase
        end
      end
    end
    req = r; we = w; size = sz; uns = u; A = a; WD = wd;
    @(negedge CLK);
  endtask

  initial begin
    logic [1:0]  rsz;
    logic [31:0] ra;

    // Reset values while held in reset.
    repeat (3) @(negedge CLK);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_RD", RD, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // Reset part-way into the fill, then a full restart with req held high.
    reset = 1'b1;
    repeat (5) @(negedge CLK);
    chk("midclear_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("midclear_rst_busy", 32'(busy), 32'd1);
    chk("midclear_rst_ready", 32'(ready), 32'd0);
    @(negedge CLK);
    req = 1'b1; we = 1'b1; size = 2'b10; A = 32'h0; WD = 32'hFFFF_FFFF;
    reset = 1'b1;
    wait_fill();

    // Directed accesses.
    step(1, 0, 2'b10, 0, 32'h3C, 0);
    step(1, 0, 2'b10, 0, 32'h00, 0);
    step(1, 1, 2'b10, 0, 32'h10, 32'h8899_AABB);
    step(1, 0, 2'b00, 0, 32'h11, 0);
    step(1, 0, 2'b00, 1, 32'h11, 0);
    step(1, 1, 2'b01, 0, 32'h12, 32'h0000_1234);
    step(1, 0, 2'b10, 0, 32'h10, 0);
    step(1, 1, 2'b10, 0, 32'h13, 32'hDEAD_BEEF);
    step(1, 0, 2'b01, 0, 32'h11, 0);
    step(1, 0, 2'b10, 0, 32'h10, 0);
    step(1, 0, 2'b11, 0, 32'h10, 0);
    step(1, 1, 2'b11, 0, 32'h14, 32'h1111_1111);
    step(1, 1, 2'b10, 0, 32'h40, 32'h5555_5555);
    step(1, 0, 2'b10, 0, 32'h00, 0);
    step(1, 0, 2'b10, 0, 32'h40, 0);
    step(0, 0, 2'b00, 0, 32'h0, 0);
    step(1, 1, 2'b10, 0, 32'h20, 32'hC001_D00D);
    step(1, 0, 2'b10, 0, 32'h20, 0);
    step(1, 1, 2'b00, 0, 32'h23, 32'h0000_0081);
    step(1, 0, 2'b00, 0, 32'h23, 0);
    step(1, 0, 2'b01, 0, 32'h22, 0);
    step(0, 0, 2'b00, 0, 32'h0, 0);

    // Randomised traffic against the byte-array model.
    for (int n = 0; n < 400; n++) begin
      rsz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        8:       ra = 32'h40 + 32'($urandom_range(0, 63));
        9:       ra = $urandom;
        default: ra = 32'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        if (rsz == 2'b01) ra[0] = 1'b0;
        if (rsz == 2'b10) ra[1:0] = 2'b00;
      end
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rsz,
           1'($urandom_range(0, 1)), ra, $urandom);
    end
    step(0, 0, 2'b00, 0, 32'h0, 0);

    // Reset with a load response pending: dropped at once, then a fresh fill.
    step(1, 0, 2'b10, 0, 32'h10, 0);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    req = 1'b0;
    #1;
    chk("arst_resp", 32'(resp_valid), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_RD", RD, 32'd0);
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd1);
    @(negedge CLK);
    reset = 1'b1;
    wait_fill();
    step(1, 0, 2'b10, 0, 32'h10, 0);
    step(1, 0, 2'b10, 0, 32'h20, 0);
    step(0, 0, 2'b00, 0, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
